// File: rtl/bus_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : bus_arb_pkg                                                |
// | Shared types and constants for the bus grant scheduler.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bus_arb_pkg;

    localparam int   NUM_CLIENTS = 4;
    localparam logic ALG_STRICT  = 1'b0;
    localparam logic ALG_RR      = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    typedef logic [1:0] client_idx_t;
    typedef logic [1:0] rank_t;

    function automatic client_idx_t onehot_to_idx(input logic [NUM_CLIENTS-1:0] oh);
        client_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (oh[i]) begin
                idx = client_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grant_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : grant_picker                                               |
// | Combinational winner selection: strict priority or round robin.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module grant_picker
    import bus_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0]       rq,
    input  logic [NUM_CLIENTS-1:0][1:0]  ranks,
    input  logic [1:0]                   last_served,
    input  logic                         mode,
    output logic [NUM_CLIENTS-1:0]       winner
);

    logic        w_found;
    rank_t       w_best_rank;
    client_idx_t w_best_idx;
    client_idx_t w_cand;

    always_comb begin
        winner      = '0;
        w_found     = 1'b0;
        w_best_rank = '0;
        w_best_idx  = '0;
        w_cand      = '0;
        if (mode == ALG_STRICT) begin
            // Strict less-than keeps the lower index on equal ranks.
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (rq[i] && (!w_found || (ranks[i] < w_best_rank))) begin
                    w_found     = 1'b1;
                    w_best_rank = ranks[i];
                    w_best_idx  = client_idx_t'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_CLIENTS; k++) begin
                w_cand = last_served + client_idx_t'(k);
                if (!w_found && rq[w_cand]) begin
                    w_found    = 1'b1;
                    w_best_idx = w_cand;
                end
            end
        end
        if (w_found) begin
            winner[w_best_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_grant_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bus_grant_scheduler                                        |
// | Arbitrates four clients onto one server port with ack timeout.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bus_grant_scheduler
    import bus_arb_pkg::*;
#(
    parameter int   CLIENT_1_PRIORITY             = 0,
    parameter int   CLIENT_2_PRIORITY             = 1,
    parameter int   CLIENT_3_PRIORITY             = 2,
    parameter int   CLIENT_4_PRIORITY             = 3,
    parameter logic PRIORITY_SCHEDULING_ALGORITHM = 1'b0,
    parameter int   ACK_TIMEOUT                   = 15
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CLIENTS-1:0]  client_rq,
    output logic [NUM_CLIENTS-1:0]  client_ack,
    output logic [NUM_CLIENTS-1:0]  grant,
    output logic                    srv_rq,
    input  logic                    srv_ack,
    output logic                    timeout_err,
    output logic [1:0]              timeout_id
);

    localparam logic [NUM_CLIENTS-1:0][1:0] c_RANKS = {
        rank_t'(CLIENT_4_PRIORITY), rank_t'(CLIENT_3_PRIORITY),
        rank_t'(CLIENT_2_PRIORITY), rank_t'(CLIENT_1_PRIORITY)
    };
    localparam logic [7:0] c_ACK_TIMEOUT = 8'(ACK_TIMEOUT);

    state_e                 state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic                   srv_rq_q, srv_rq_d;
    logic [7:0]             timer_q, timer_d;
    client_idx_t            last_served_q, last_served_d;
    logic                   timeout_err_q, timeout_err_d;
    client_idx_t            timeout_id_q, timeout_id_d;

    logic [NUM_CLIENTS-1:0] w_winner;
    client_idx_t            w_owner_idx;

    grant_picker u_picker (
        .rq          (client_rq),
        .ranks       (c_RANKS),
        .last_served (last_served_q),
        .mode        (PRIORITY_SCHEDULING_ALGORITHM),
        .winner      (w_winner)
    );

    assign w_owner_idx = onehot_to_idx(grant_q);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        srv_rq_d      = srv_rq_q;
        timer_d       = timer_q;
        last_served_d = last_served_q;
        timeout_err_d = 1'b0;
        timeout_id_d  = timeout_id_q;
        case (state_q)
            ST_IDLE: begin
                if (client_rq != '0) begin
                    grant_d  = w_winner;
                    srv_rq_d = 1'b1;
                    timer_d  = '0;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // An ack in the timeout cycle still completes normally.
                if (srv_ack) begin
                    grant_d       = '0;
                    srv_rq_d      = 1'b0;
                    last_served_d = w_owner_idx;
                    state_d       = ST_RELEASE;
                end else if (timer_q >= c_ACK_TIMEOUT) begin
                    grant_d       = '0;
                    srv_rq_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    timeout_id_d  = w_owner_idx;
                    state_d       = ST_RELEASE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                grant_d  = '0;
                srv_rq_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            srv_rq_q      <= 1'b0;
            timer_q       <= '0;
            last_served_q <= 2'd3;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            srv_rq_q      <= srv_rq_d;
            timer_q       <= timer_d;
            last_served_q <= last_served_d;
            timeout_err_q <= timeout_err_d;
            timeout_id_q  <= timeout_id_d;
        end
    end

    assign client_ack  = ((state_q == ST_GRANT) && srv_ack) ? grant_q : '0;
    assign grant       = grant_q;
    assign srv_rq      = srv_rq_q;
    assign timeout_err = timeout_err_q;
    assign timeout_id  = timeout_id_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_grant_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bus_grant_scheduler                                     |
// | Three scheduler configurations driven in lockstep against a model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bus_grant_scheduler;

    localparam int ND = 3;
    localparam int TO = 15;
    localparam int RANK [ND][4] = '{'{0, 1, 2, 3}, '{0, 1, 2, 3}, '{1, 2, 3, 0}};
    localparam int MODE [ND]    = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] client_rq;
    logic       srv_ack;

    logic [3:0] client_ack_w  [ND];
    logic [3:0] grant_w       [ND];
    logic       srv_rq_w      [ND];
    logic       timeout_err_w [ND];
    logic [1:0] timeout_id_w  [ND];

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 owner holds the server, 2 release gap.
    int m_phase [ND];
    int m_owner [ND];
    int m_age   [ND];
    int m_last  [ND];
    int m_tid   [ND];
    bit m_terr  [ND];

    always #5 clk = ~clk;

    bus_grant_scheduler #(
        .CLIENT_1_PRIORITY(0), .CLIENT_2_PRIORITY(1), .CLIENT_3_PRIORITY(2), .CLIENT_4_PRIORITY(3),
        .PRIORITY_SCHEDULING_ALGORITHM(1'b0), .ACK_TIMEOUT(TO)
    ) dut_strict (
        .clk(clk), .reset(reset), .client_rq(client_rq), .client_ack(client_ack_w[0]),
        .grant(grant_w[0]), .srv_rq(srv_rq_w[0]), .srv_ack(srv_ack),
        .timeout_err(timeout_err_w[0]), .timeout_id(timeout_id_w[0])
    );

    bus_grant_scheduler #(
        .CLIENT_1_PRIORITY(0), .CLIENT_2_PRIORITY(1), .CLIENT_3_PRIORITY(2), .CLIENT_4_PRIORITY(3),
        .PRIORITY_SCHEDULING_ALGORITHM(1'b1), .ACK_TIMEOUT(TO)
    ) dut_rr (
        .clk(clk), .reset(reset), .client_rq(client_rq), .client_ack(client_ack_w[1]),
        .grant(grant_w[1]), .srv_rq(srv_rq_w[1]), .srv_ack(srv_ack),
        .timeout_err(timeout_err_w[1]), .timeout_id(timeout_id_w[1])
    );

    bus_grant_scheduler #(
        .CLIENT_1_PRIORITY(1), .CLIENT_2_PRIORITY(2), .CLIENT_3_PRIORITY(3), .CLIENT_4_PRIORITY(0),
        .PRIORITY_SCHEDULING_ALGORITHM(1'b0), .ACK_TIMEOUT(TO)
    ) dut_rank (
        .clk(clk), .reset(reset), .client_rq(client_rq), .client_ack(client_ack_w[2]),
        .grant(grant_w[2]), .srv_rq(srv_rq_w[2]), .srv_ack(srv_ack),
        .timeout_err(timeout_err_w[2]), .timeout_id(timeout_id_w[2])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Strict: smallest rank*4+index wins. RR: smallest cyclic distance past last.
    function automatic int pick(input int d, input logic [3:0] rq, input int last);
        int best;
        int best_key;
        int key;
        best     = -1;
        best_key = 1000;
        for (int i = 0; i < 4; i++) begin
            if (rq[i]) begin
                if (MODE[d] != 0) key = (i - last - 1 + 8) % 4;
                else              key = RANK[d][i] * 4 + i;
                if (key < best_key) begin
                    best_key = key;
                    best     = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_phase[d] = 0;
            m_owner[d] = 0;
            m_age[d]   = 0;
            m_last[d]  = 3;
            m_tid[d]   = 0;
            m_terr[d]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < ND; d++) begin
            m_terr[d] = 1'b0;
            if (m_phase[d] == 0) begin
                if (client_rq != 4'b0000) begin
                    m_owner[d] = pick(d, client_rq, m_last[d]);
                    m_age[d]   = 0;
                    m_phase[d] = 1;
                end
            end else if (m_phase[d] == 1) begin
                if (srv_ack) begin
                    m_last[d]  = m_owner[d];
                    m_phase[d] = 2;
                end else if (m_age[d] == TO) begin
                    m_terr[d]  = 1'b1;
                    m_tid[d]   = m_owner[d];
                    m_phase[d] = 2;
                end else begin
                    m_age[d]++;
                end
            end else begin
                m_phase[d] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < ND; d++) begin
            logic [3:0] eg;
            logic [3:0] ea;
            eg = (m_phase[d] == 1) ? (4'b0001 << m_owner[d]) : 4'b0000;
            ea = (m_phase[d] == 1 && srv_ack) ? eg : 4'b0000;
            chk($sformatf("grant[%0d]", d), {4'b0, grant_w[d]}, {4'b0, eg});
            chk($sformatf("srv_rq[%0d]", d), {7'b0, srv_rq_w[d]}, {7'b0, m_phase[d] == 1});
            chk($sformatf("client_ack[%0d]", d), {4'b0, client_ack_w[d]}, {4'b0, ea});
            chk($sformatf("timeout_err[%0d]", d), {7'b0, timeout_err_w[d]}, {7'b0, m_terr[d]});
            chk($sformatf("onehot0[%0d]", d), {7'b0, $onehot0(grant_w[d])}, 8'd1);
            if (m_terr[d] || reset) begin
                chk($sformatf("timeout_id[%0d]", d), {6'b0, timeout_id_w[d]}, 8'(m_tid[d]));
            end
        end
    endtask

    // Inputs change on the falling edge; checks sit 1 ns later, well clear of posedge.
    task automatic cycle(input logic r, input logic [3:0] rq, input logic ack);
        reset     = r;
        client_rq = rq;
        srv_ack   = ack;
        if (r) model_reset();
        #1;
        check_all();
        @(posedge clk);
        if (r) model_reset();
        else   model_step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [5];
        logic [3:0] rq;
        logic       ack;
        int         quiet;

        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        reset = 1'b1; client_rq = 4'b0000; srv_ack = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state, with a stray ack that must be ignored.
        cycle(1'b1, 4'b1111, 1'b1);
        cycle(1'b1, 4'b0000, 1'b0);

        // Strict default picks client 2; reranked instance picks client 4.
        cycle(1'b0, 4'b1010, 1'b0);
        chk("strict_1010", {4'b0, grant_w[0]}, 8'b0000_0010);
        chk("rank4_1001ish", {4'b0, grant_w[2]}, 8'b0000_1000);
        chk("strict_srv_rq", {7'b0, srv_rq_w[0]}, 8'd1);
        cycle(1'b0, 4'b1010, 1'b0);
        cycle(1'b0, 4'b1010, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b1001, 1'b0);
        chk("rank4_1001", {4'b0, grant_w[2]}, 8'b0000_1000);
        cycle(1'b0, 4'b1001, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);

        // Round robin rotation with ack two cycles after srv_rq.
        cycle(1'b1, 4'b0000, 1'b0);
        for (int t = 0; t < 5; t++) begin
            cycle(1'b0, 4'b1111, 1'b0);
            chk($sformatf("rr_seq%0d", t), {4'b0, grant_w[1]}, {4'b0, seq[t]});
            cycle(1'b0, 4'b1111, 1'b0);
            cycle(1'b0, 4'b1111, 1'b0);
            cycle(1'b0, 4'b1111, 1'b1);
            cycle(1'b0, 4'b1111, 1'b0);
        end

        // Timeout on client 3.
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < TO + 1; i++) cycle(1'b0, 4'b0100, 1'b0);
        chk("to_err", {7'b0, timeout_err_w[0]}, 8'd1);
        chk("to_id", {6'b0, timeout_id_w[0]}, 8'd2);
        chk("to_grant", {4'b0, grant_w[0]}, 8'd0);
        cycle(1'b0, 4'b0000, 1'b0);
        chk("to_pulse_end", {7'b0, timeout_err_w[0]}, 8'd0);

        // Ack in the very cycle the timer reaches its limit.
        cycle(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < TO; i++) cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b0, 4'b0100, 1'b1);
        chk("edge_no_to", {7'b0, timeout_err_w[0]}, 8'd0);
        cycle(1'b0, 4'b0000, 1'b0);

        // Reset in the middle of a grant, then round robin restarts at client 1.
        cycle(1'b0, 4'b1111, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0);
        chk("rst_rr_first", {4'b0, grant_w[1]}, 8'b0000_0001);
        cycle(1'b0, 4'b1111, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);

        // Randomized traffic, with quiet stretches that let timeouts happen.
        rq    = 4'b0000;
        quiet = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            if (quiet > 0) begin
                quiet--;
                ack = 1'b0;
            end else begin
                ack = ($urandom_range(0, 99) < 25);
                if ($urandom_range(0, 39) == 0) quiet = 20;
            end
            cycle($urandom_range(0, 249) == 0, rq, ack);
        end
        cycle(1'b0, 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_grant_scheduler.md
BUS_GRANT_SCHEDULER -- requirements
Module: bus_grant_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  CLIENT_1_PRIORITY, 0, rank of client 1; 0 = highest.
  CLIENT_2_PRIORITY, 1, rank of client 2.
  CLIENT_3_PRIORITY, 2, rank of client 3.
  CLIENT_4_PRIORITY, 3, rank of client 4.
  PRIORITY_SCHEDULING_ALGORITHM, 1'b0, 0 = strict priority; 1 = round robin.
  ACK_TIMEOUT, 15, max GRANT cycles without srv_ack; range 1..255.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on rising edge.
  reset  input  1  asynchronous, active-high reset.
  client_rq  input  4  bit i = request of client i+1; held until its ack.
  client_ack  output  4  one-cycle completion pulse per client.
  grant  output  4  one-hot owner of the server port; 0 = none.
  srv_rq  output  1  request to the shared server (ram).
  srv_ack  input  1  server completion pulse.
  timeout_err  output  1  one-cycle pulse on ack timeout.
  timeout_id  output  2  client index of the timed-out grant; valid with timeout_err.

Function
REQ-003 FSM states SHALL be IDLE, GRANT, RELEASE.
REQ-004 IDLE: if client_rq != 0, the next edge SHALL load grant with the winner, set srv_rq=1, clear the timer, and enter GRANT; otherwise the FSM stays in IDLE.
REQ-005 Strict mode: winner SHALL be the requester with the lowest CLIENT_n_PRIORITY value; equal values resolve to the lower client index.
REQ-006 Round-robin mode: winner SHALL be the first requester found searching cyclically from last_served+1; last_served SHALL update only on srv_ack.
REQ-007 GRANT: grant and srv_rq SHALL stay stable; the timer SHALL increment by 1 per cycle.
REQ-008 On srv_ack=1 in GRANT: client_ack SHALL equal grant combinationally in that cycle; the next edge SHALL clear srv_rq and grant and enter RELEASE.
REQ-009 If the timer reaches ACK_TIMEOUT without srv_ack, the next edge SHALL pulse timeout_err for one cycle with timeout_id=owner, clear grant and srv_rq, enter RELEASE, and leave client_ack low.
REQ-010 If srv_ack and timeout coincide in one cycle, srv_ack SHALL win and no timeout_err SHALL fire.
REQ-011 RELEASE SHALL last exactly one cycle, with srv_rq=0 and grant=0, then go to IDLE; back-to-back transactions are at least 1 cycle apart on srv_rq.
REQ-012 srv_ack outside GRANT SHALL be ignored; client_ack SHALL stay 0 and the state SHALL not change.
REQ-013 client_rq dropping during GRANT SHALL NOT abort the transaction; it completes per REQ-008.
REQ-014 grant SHALL never have more than one bit set.

Reset
REQ-015 While reset=1: state=IDLE, grant=0, srv_rq=0, client_ack=0, timeout_err=0, timeout_id=0, timer=0, last_served=3 (client 1 searched first).
REQ-016 Reset asserted mid-GRANT SHALL drop srv_rq and grant immediately and asynchronously, with no client_ack and no timeout_err.

Structure
REQ-017 State encoding, NUM_CLIENTS=4 and ALG_STRICT/ALG_RR constants SHALL live in shared package bus_arb_pkg.
REQ-018 Winner selection SHALL be a combinational sub-module grant_picker (inputs: rq, ranks, last_served, mode; output: one-hot winner).

Verification
REQ-019 Strict, default ranks, client_rq=4'b1010 in IDLE -> grant=4'b0010 next cycle, srv_rq=1.
REQ-020 RR, client_rq held at 4'b1111, srv_ack 2 cycles after each srv_rq -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-021 Strict, CLIENT_4_PRIORITY=0 and others 1..3, client_rq=4'b1001 -> grant=4'b1000.
REQ-022 srv_ack held 0, ACK_TIMEOUT=15, grant=4'b0100 -> timeout_err pulse, timeout_id=2, client_ack=0, RELEASE, then IDLE.
REQ-023 srv_ack on the same cycle the timer reaches 15 -> client_ack pulse, timeout_err=0.
REQ-024 reset pulsed during GRANT -> srv_rq=0 and grant=0 before the next edge; after release, client_rq=4'b1111 in RR -> grant=4'b0001.
